aac_pcm_writer: RTL and testbench
=================================

Name: aac_pcm_writer

Overview:
- Upstream feeder of the AAC decoder's AXI write-master stage.
- Accepts decoded PCM words from the synthesis filterbank through a valid/ready stream and buffers them in a small FIFO.
- Generates sequential word addresses into a circular output buffer in system memory.
- Issues one single-beat write request at a time to the write master and waits for its write-response completion before issuing the next.

Parameters:
FIFO_DEPTH, 8, PCM word FIFO entries; power of two, 2..64
FIFO_AW, 3, log2(FIFO_DEPTH)
ERR_W, 8, width of write-error counter

Ports:
aclk  in  1  clock
aresetn  in  1  reset, asynchronous, active-low
start  in  1  one-cycle pulse; reload write pointer to buf_base, clear words_written
buf_base  in  32  output buffer byte base address; bits [1:0] ignored (treated 0)
buf_words  in  16  buffer length in 32-bit words; 0 treated as 65536
pcm_data  in  32  decoded PCM word (L/R packed 16+16)
pcm_valid  in  1  pcm_data valid
pcm_ready  out  1  FIFO can accept (not full)
wr_addr  out  32  request address to write master
wr_data  out  32  request data to write master
wr_addr_valid  out  1  address valid, one-cycle pulse per request
wr_data_valid  out  1  data valid, held until completion
wr_resp_valid  in  1  write completed (B-channel handshake bvalid&bready, registered by integration)
wr_resp  in  2  bresp of completed write
fifo_level  out  FIFO_AW+1  current FIFO occupancy
words_written  out  16  completed writes since start, wraps at 65535->0
err_count  out  ERR_W  completions with wr_resp!=2'b00, saturating
wrap_pulse  out  1  one cycle when pointer wraps to buf_base
busy  out  1  FSM not IDLE or FIFO non-empty

Behaviour:
- Reset values: pcm_ready=0, wr_addr=0, wr_data=0, wr_addr_valid=0, wr_data_valid=0, fifo_level=0, words_written=0, err_count=0, wrap_pulse=0, busy=0.
- Reset also applies: FSM=IDLE, internal pointer=0, offset=0, FIFO empty.
- Reset mid-transfer abandons the request; no completion is counted.
- pcm_ready=1 once out of reset whenever fifo_level<FIFO_DEPTH.
- Push occurs on pcm_valid&pcm_ready. A push and a pop in the same cycle leave the level unchanged; a push while full is impossible.
- FIFO is registered: a pushed word is visible to the FSM the cycle after the push. Minimum latency from push to wr_addr_valid is 2 cycles.
- FSM states:
  - IDLE: if FIFO non-empty, latch wr_addr=ptr and wr_data=FIFO head. Go to ADDR.
  - ADDR: wr_addr_valid=1 for exactly this cycle; wr_data_valid=1 from this cycle. Go to DATA.
  - DATA: hold wr_addr, wr_data and wr_data_valid=1 until wr_resp_valid. Then:
    - pop FIFO;
    - wr_data_valid=0;
    - increment words_written;
    - if wr_resp!=0, err_count+=1, saturating at all-ones;
    - advance the pointer;
    - go to IDLE.
  - A wr_resp_valid arriving in ADDR is also accepted: perform the DATA completion actions and go directly to IDLE.
- wr_resp_valid in IDLE is ignored.
- Pointer advance:
  - offset+1; if the result equals buf_words, offset=0 and wrap_pulse=1 for that cycle.
  - ptr = {buf_base[31:2],2'b00} + (offset<<2), computed with 32-bit wrap-around arithmetic.
- start:
  - In IDLE: offset=0, words_written=0; the FIFO is not flushed.
  - In ADDR/DATA: the current request completes normally; the reload is applied on return to IDLE and takes priority over the advance. The completion still increments words_written before clearing; the net result is words_written=0.
- Error responses do not retry; the data is dropped and the pointer still advances.
- One outstanding request maximum; requests are strictly in FIFO order.
- busy=0 only when IDLE and the FIFO is empty.

Decomposition:
- Package aac_axi_pkg holds:
  - FSM typedef (IDLE, ADDR, DATA);
  - AXI response constants: OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11;
  - default buffer-size constant.
- One sub-module, aac_sync_fifo: parameterised synchronous FIFO with push, pop, head, level, full and empty; async active-low reset.
- Pointer, counters and FSM stay in the top level.

Test Plan:
- Basic write: base=0x1000_0000, buf_words=4; push 0xAAAA5555 → one wr_addr_valid pulse with wr_addr=0x1000_0000 and wr_data=0xAAAA5555. After wr_resp_valid=1 with wr_resp=00: words_written=1, fifo_level=0, busy=0.
- Wrap: buf_words=3; push 4 words, respond OKAY to each → addresses 0x...00, 0x...04, 0x...08, 0x...00. wrap_pulse fires once, on the 3rd completion.
- Backpressure: FIFO_DEPTH=8; withhold wr_resp_valid, push 10 words → pcm_ready drops after fifo_level reaches 8. Releasing responses drains all 10 in order, with no loss or duplication.
- Errors: respond SLVERR, DECERR, OKAY → err_count=2, words_written=3, pointer advanced 3 words. Force 300 errors with ERR_W=8 → err_count stays at 255.
- start during DATA: pulse start while a write at offset 2 is pending, then complete → next request is at buf_base and words_written=0.
- Async reset mid-DATA: drop aresetn for 1 cycle → all outputs return to reset values immediately. After release, pushes restart from address 0 until start is pulsed.

Source files
------------

// File: rtl/aac_axi_pkg.sv
// aac_axi_pkg: shared FSM encoding, AXI response codes and buffer defaults for the PCM writer
package aac_axi_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t ADDR = 2'd1;
    localparam state_t DATA = 2'd2;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    localparam logic [15:0] DEF_BUF_WORDS = 16'd1024;

endpackage

// File: rtl/aac_pcm_writer_if.sv
// aac_pcm_writer_if: PCM input stream plus single-beat write request/response towards the write master
interface aac_pcm_writer_if;

    logic [31:0] pcm_data;
    logic        pcm_valid;
    logic        pcm_ready;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        wr_addr_valid;
    logic        wr_data_valid;
    logic        wr_resp_valid;
    logic [1:0]  wr_resp;

    modport master (
        input  pcm_data, pcm_valid, wr_resp_valid, wr_resp,
        output pcm_ready, wr_addr, wr_data, wr_addr_valid, wr_data_valid
    );

    modport slave (
        output pcm_data, pcm_valid, wr_resp_valid, wr_resp,
        input  pcm_ready, wr_addr, wr_data, wr_addr_valid, wr_data_valid
    );

endinterface

// File: rtl/aac_sync_fifo.sv
// aac_sync_fifo: registered synchronous FIFO; head shows the oldest entry, level counts occupancy
module aac_sync_fifo #(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int DW    = 32
) (
    input  logic          aclk,
    input  logic          aresetn,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] head,
    output logic [AW:0]   level,
    output logic          full,
    output logic          empty
);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;

    assign head  = mem[rp];
    assign full  = level == (AW+1)'(DEPTH);
    assign empty = level == '0;

    // storage needs no reset; only the pointers define validity
    always_ff @(posedge aclk) begin
        if (push) mem[wp] <= din;
    end

    // pointer and occupancy bookkeeping; simultaneous push/pop keeps the level
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wp    <= '0;
            rp    <= '0;
            level <= '0;
        end else begin
            wp    <= wp + AW'(push);
            rp    <= rp + AW'(pop);
            level <= level + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

endmodule

// File: rtl/aac_pcm_writer.sv
// aac_pcm_writer: buffers PCM words and writes them one at a time into a circular memory buffer
module aac_pcm_writer
    import aac_axi_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int FIFO_AW    = 3,
    parameter int ERR_W      = 8
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 start,
    input  logic [31:0]          buf_base,
    input  logic [15:0]          buf_words,
    aac_pcm_writer_if.master     bus,
    output logic [FIFO_AW:0]     fifo_level,
    output logic [15:0]          words_written,
    output logic [ERR_W-1:0]     err_count,
    output logic                 wrap_pulse,
    output logic                 busy
);

    state_t      state;
    logic [31:0] ptr;
    logic [15:0] offset;
    logic        pend;
    logic        en;
    logic [31:0] head;
    logic        full;
    logic        empty;
    logic        push;
    logic        done;
    logic        reload;
    logic        wrap;
    logic [16:0] off_inc;
    logic [16:0] off_lim;
    logic [15:0] nxt_off;
    logic [31:0] base_al;
    logic [31:0] nxt_ptr;

    aac_sync_fifo #(.DEPTH(FIFO_DEPTH), .AW(FIFO_AW), .DW(32)) u_fifo (
        .aclk   (aclk),
        .aresetn(aresetn),
        .push   (push),
        .pop    (done),
        .din    (bus.pcm_data),
        .head   (head),
        .level  (fifo_level),
        .full   (full),
        .empty  (empty)
    );

    assign bus.pcm_ready     = en & ~full;
    assign push              = bus.pcm_valid & bus.pcm_ready;
    assign bus.wr_addr_valid = state == ADDR;
    assign bus.wr_data_valid = state != IDLE;
    assign busy              = state != IDLE || !empty;

    // completion and next-pointer arithmetic; a zero length means the full 65536-word buffer
    always_comb begin
        base_al = {buf_base[31:2], 2'b00};
        off_inc = {1'b0, offset} + 17'd1;
        off_lim = buf_words == '0 ? 17'h10000 : {1'b0, buf_words};
        wrap    = off_inc == off_lim;
        nxt_off = wrap ? 16'd0 : off_inc[15:0];
        nxt_ptr = base_al + {14'd0, nxt_off, 2'b00};
        done    = state != IDLE && bus.wr_resp_valid;
        reload  = start || pend;
    end

    // pcm_ready stays low until the first clock after reset release
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) en <= 1'b0;
        else          en <= 1'b1;
    end

    // request FSM: latch head and pointer, present address for one cycle, hold data until completion
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state       <= IDLE;
            bus.wr_addr <= '0;
            bus.wr_data <= '0;
        end else if (state == IDLE && !empty) begin
            bus.wr_addr <= start ? base_al : ptr;
            bus.wr_data <= head;
            state       <= ADDR;
        end else if (done) begin
            state <= IDLE;
        end else if (state == ADDR) begin
            state <= DATA;
        end
    end

    // write pointer: advance on completion, a start seen mid-request is deferred and wins over the advance
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            offset     <= '0;
            ptr        <= '0;
            pend       <= 1'b0;
            wrap_pulse <= 1'b0;
        end else begin
            wrap_pulse <= done && !reload && wrap;
            if (done) begin
                pend   <= 1'b0;
                offset <= reload ? 16'd0 : nxt_off;
                ptr    <= reload ? base_al : nxt_ptr;
            end else if (start && state == IDLE) begin
                offset <= '0;
                ptr    <= base_al;
            end else if (start) begin
                pend <= 1'b1;
            end
        end
    end

    // completion counters; the error count saturates instead of wrapping
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            words_written <= '0;
            err_count     <= '0;
        end else begin
            if (done) words_written <= reload ? 16'd0 : words_written + 16'd1;
            else if (start && state == IDLE) words_written <= '0;
            if (done && bus.wr_resp != OKAY && err_count != '1) err_count <= err_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_aac_pcm_writer.sv
// tb_aac_pcm_writer: randomized scoreboard bench with a behavioural circular-buffer model
module tb_aac_pcm_writer;
    import aac_axi_pkg::*;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        start = 1'b0;
    logic [31:0] buf_base = '0;
    logic [15:0] buf_words = DEF_BUF_WORDS;
    logic [3:0]  fifo_level;
    logic [15:0] words_written;
    logic [7:0]  err_count;
    logic        wrap_pulse;
    logic        busy;

    aac_pcm_writer_if bus();

    aac_pcm_writer #(.FIFO_DEPTH(8), .FIFO_AW(3), .ERR_W(8)) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .start        (start),
        .buf_base     (buf_base),
        .buf_words    (buf_words),
        .bus          (bus),
        .fifo_level   (fifo_level),
        .words_written(words_written),
        .err_count    (err_count),
        .wrap_pulse   (wrap_pulse),
        .busy         (busy)
    );

    always #5 aclk = ~aclk;

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_q [$];
    logic [1:0]  resp_q [$];
    logic [31:0] m_base = '0;
    logic [31:0] m_ptr = '0;
    int          m_lim = 1024;
    int          m_off = 0;
    int          m_ww = 0;
    int          m_err = 0;
    int          m_wraps = 0;
    bit          m_pend = 0;
    int          wrap_cnt = 0;
    bit          hold = 0;
    int          mode = 0;
    int          max_dly = 2;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic set_buf(input logic [31:0] b, input logic [15:0] w);
        buf_base  = b;
        buf_words = w;
        m_base    = {b[31:2], 2'b00};
        m_lim     = w == 0 ? 65536 : int'(w);
    endtask

    task automatic do_start(input bit pending);
        @(posedge aclk); #1;
        start = 1'b1;
        if (pending) m_pend = 1;
        else begin
            m_off = 0;
            m_ptr = m_base;
            m_ww  = 0;
        end
        @(posedge aclk); #1;
        start = 1'b0;
    endtask

    task automatic push(input logic [31:0] d);
        int t;
        t = 0;
        @(posedge aclk); #1;
        bus.pcm_data  = d;
        bus.pcm_valid = 1'b1;
        @(negedge aclk);
        while (!bus.pcm_ready && t < 1000) begin
            @(negedge aclk);
            t++;
        end
        if (!bus.pcm_ready) check("push_timeout", 32'd0, 32'd1);
        else exp_q.push_back(d);
        @(posedge aclk); #1;
        bus.pcm_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        do begin
            @(negedge aclk);
            t++;
        end while ((exp_q.size() != 0 || busy || bus.wr_resp_valid) && t < 3000);
        if (t >= 3000) check("drain_timeout", 32'd0, 32'd1);
        @(negedge aclk);
    endtask

    task automatic wait_req();
        int t;
        t = 0;
        @(negedge aclk);
        while (!bus.wr_data_valid && t < 100) begin
            @(negedge aclk);
            t++;
        end
        if (!bus.wr_data_valid) check("req_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_words_written"}, 32'(words_written), 32'(m_ww & 16'hffff));
        check({tag, "_err_count"}, 32'(err_count), m_err > 255 ? 32'd255 : 32'(m_err));
        check({tag, "_wraps"}, 32'(wrap_cnt), 32'(m_wraps));
        check({tag, "_idle"}, {27'd0, fifo_level, busy}, 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pcm_ready"}, 32'(bus.pcm_ready), 32'd0);
        check({tag, "_wr_addr"}, bus.wr_addr, 32'd0);
        check({tag, "_wr_data"}, bus.wr_data, 32'd0);
        check({tag, "_valids"}, {30'd0, bus.wr_addr_valid, bus.wr_data_valid}, 32'd0);
        check({tag, "_fifo_level"}, 32'(fifo_level), 32'd0);
        check({tag, "_words_written"}, 32'(words_written), 32'd0);
        check({tag, "_err_count"}, 32'(err_count), 32'd0);
        check({tag, "_wrap_busy"}, {30'd0, wrap_pulse, busy}, 32'd0);
    endtask

    // monitor: every address pulse must match the next pushed word at the model's pointer
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge aclk);
            if (bus.wr_addr_valid) begin
                if (exp_q.size() == 0) check("unexpected_request", bus.wr_data, 32'hxxxxxxxx);
                else begin
                    e = exp_q.pop_front();
                    check("req_addr", bus.wr_addr, m_ptr);
                    check("req_data", bus.wr_data, e);
                end
            end
        end
    end

    always @(negedge aclk) if (wrap_pulse) wrap_cnt++;

    // responder: completes each request after a random delay and advances the model
    initial begin
        int d;
        logic [1:0] code;
        bus.wr_resp_valid = 1'b0;
        bus.wr_resp       = OKAY;
        forever begin
            @(negedge aclk);
            if (bus.wr_data_valid && !hold && aresetn) begin
                d = $urandom_range(0, max_dly);
                repeat (d) @(negedge aclk);
                if (resp_q.size() != 0) code = resp_q.pop_front();
                else if (mode == 0) code = OKAY;
                else if (mode == 1) code = 2'($urandom_range(1, 3));
                else code = 2'($urandom_range(0, 3));
                m_ww = m_pend ? 0 : m_ww + 1;
                if (code != OKAY) m_err++;
                if (m_pend) begin
                    m_off  = 0;
                    m_pend = 0;
                end else begin
                    m_off++;
                    if (m_off == m_lim) begin
                        m_off = 0;
                        m_wraps++;
                    end
                end
                m_ptr = m_base + 32'(m_off * 4);
                bus.wr_resp       = code;
                bus.wr_resp_valid = 1'b1;
                @(negedge aclk);
                bus.wr_resp_valid = 1'b0;
            end
        end
    end

    initial begin
        bus.pcm_valid = 1'b0;
        bus.pcm_data  = '0;
        #2;
        check_reset_outputs("reset");
        repeat (3) @(negedge aclk);
        aresetn = 1'b1;
        repeat (2) @(negedge aclk);
        check("ready_after_reset", 32'(bus.pcm_ready), 32'd1);

        set_buf(32'h1000_0000, 16'd4);
        do_start(0);
        push(32'hAAAA5555);
        drain();
        check_counters("basic");

        set_buf(32'h1000_0000, 16'd3);
        do_start(0);
        repeat (4) push($urandom);
        drain();
        check_counters("wrap");

        set_buf(32'h3000_0000, 16'd16);
        do_start(0);
        hold = 1;
        repeat (8) push($urandom);
        repeat (3) @(negedge aclk);
        check("bp_level", 32'(fifo_level), 32'd8);
        check("bp_ready", 32'(bus.pcm_ready), 32'd0);
        hold = 0;
        repeat (2) push($urandom);
        drain();
        check_counters("backpressure");

        set_buf(32'h4000_0003, 16'd64);
        do_start(0);
        resp_q.push_back(SLVERR);
        resp_q.push_back(DECERR);
        resp_q.push_back(OKAY);
        repeat (3) push($urandom);
        drain();
        check_counters("errors");
        push($urandom);
        drain();

        mode    = 1;
        max_dly = 0;
        repeat (300) push($urandom);
        drain();
        mode    = 0;
        max_dly = 2;
        check_counters("saturate");

        set_buf(32'h2000_0000, 16'd8);
        do_start(0);
        repeat (2) push($urandom);
        drain();
        hold = 1;
        push(32'h1234_5678);
        wait_req();
        do_start(1);
        hold = 0;
        drain();
        check_counters("start_pending");
        push(32'h8765_4321);
        drain();
        check_counters("after_start");

        for (int p = 0; p < 2; p++) begin
            set_buf(p == 0 ? 32'hFFFF_FFFA : $urandom, p == 0 ? 16'd5 : 16'($urandom_range(1, 6)));
            do_start(0);
            mode = 2;
            for (int i = 0; i < 40; i++) begin
                push($urandom);
                repeat ($urandom_range(0, 3)) @(posedge aclk);
            end
            drain();
            mode = 0;
            check_counters("random");
        end

        hold = 1;
        push($urandom);
        wait_req();
        #2 aresetn = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        exp_q.delete();
        m_off  = 0;
        m_ptr  = '0;
        m_ww   = 0;
        m_err  = 0;
        m_pend = 0;
        @(negedge aclk);
        aresetn = 1'b1;
        hold = 0;
        push(32'hCAFE_0001);
        drain();
        check_counters("post_reset");
        set_buf(32'h5000_0000, 16'd4);
        do_start(0);
        push(32'hCAFE_0002);
        drain();
        check_counters("post_reset_start");

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
